// File: rtl/maze_map_loader.sv
// Maze map loader: reads one maze level from a row-organised ROM into a
// shadow map, then publishes it to the active map on an end-of-frame pulse,
// so the draw path never observes a half-loaded maze. While idle, single
// cells of the active map may be edited.
//
// Ports
//   i_Clk, i_Rst              clock, asynchronous active-low reset
//   i_Start, i_Level          load request pulse and requested level (11 -> 10)
//   o_RomReq, o_RomAddr       ROM row read request / address (level*ROWS+row)
//   i_RomAck, i_RomData       ROM acknowledge with same-cycle row bitmap
//   i_FrameDone               end-of-frame pulse from the draw path
//   i_CellWe/Row/Col/Val      single-cell write to the active map
//   o_CellRdy                 cell write accepted this cycle (combinational)
//   o_MazeMap, o_MazeLevel    active map and its level
//   o_Busy, o_Done, o_Err     loading, completion pulse, sticky timeout error
module maze_map_loader #(
    parameter int unsigned ROWS    = 30,
    parameter int unsigned COLS    = 40,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Start,
    input  logic [1:0]             i_Level,
    output logic                   o_RomReq,
    output logic [6:0]             o_RomAddr,
    input  logic                   i_RomAck,
    input  logic [COLS-1:0]        i_RomData,
    input  logic                   i_FrameDone,
    input  logic                   i_CellWe,
    input  logic [4:0]             i_CellRow,
    input  logic [5:0]             i_CellCol,
    input  logic                   i_CellVal,
    output logic                   o_CellRdy,
    output logic [ROWS*COLS-1:0]   o_MazeMap,
    output logic [1:0]             o_MazeLevel,
    output logic                   o_Busy,
    output logic                   o_Done,
    output logic                   o_Err
);

    localparam int unsigned MAP_W = ROWS * COLS;
    localparam int unsigned IDX_W = $clog2(MAP_W);
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_NEXT,
        S_WAIT_FRAME,
        S_SWAP
    } state_e;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [MAP_W-1:0]   shadow_q, shadow_d;
    logic [MAP_W-1:0]   map_q, map_d;
    logic [1:0]         mlvl_q, mlvl_d;
    logic               req_q, req_d;
    logic [6:0]         addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cell_ok_c;
    logic [IDX_W-1:0]   cell_idx_c;
    logic [IDX_W-1:0]   row_base_c;

    // ROM row address for a level/row pair, 7-bit unsigned result
    function automatic logic [6:0] rom_addr(input logic [1:0] lvl, input logic [ROW_W-1:0] row);
        return 7'(lvl) * 7'(ROWS) + 7'(row);
    endfunction

    // Cell writes only land while idle and in range; reset also blocks them
    assign cell_ok_c  = i_Rst && i_CellWe && (state_q == S_IDLE)
                        && (32'(i_CellRow) < ROWS) && (32'(i_CellCol) < COLS);
    assign cell_idx_c = IDX_W'(i_CellRow) * IDX_W'(COLS) + IDX_W'(i_CellCol);
    assign row_base_c = IDX_W'(row_q) * IDX_W'(COLS);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        lvl_d    = lvl_q;
        shadow_d = shadow_q;
        map_d    = map_q;
        mlvl_d   = mlvl_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    lvl_d   = (i_Level == 2'b11) ? 2'b10 : i_Level;
                    row_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_RomAck) begin
                    shadow_d[row_base_c +: COLS] = i_RomData;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    // Give up: the half-built shadow is thrown away, active map untouched
                    if (cnt_d == TO_W'(TIMEOUT)) begin
                        err_d    = 1'b1;
                        shadow_d = '0;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_NEXT: begin
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = S_WAIT_FRAME;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_WAIT_FRAME: begin
                if (i_FrameDone) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                map_d   = shadow_q;
                mlvl_d  = lvl_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cell_ok_c) begin
            map_d[cell_idx_c] = i_CellVal;
        end

        // Outputs are registered from the upcoming state so they align with it
        req_d  = (state_d == S_REQ);
        addr_d = req_d ? rom_addr(lvl_d, row_d) : 7'd0;
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            cnt_q    <= '0;
            lvl_q    <= 2'b00;
            shadow_q <= '0;
            map_q    <= '0;
            mlvl_q   <= 2'b00;
            req_q    <= 1'b0;
            addr_q   <= 7'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            shadow_q <= shadow_d;
            map_q    <= map_d;
            mlvl_q   <= mlvl_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_RomReq    = req_q;
    assign o_RomAddr   = addr_q;
    assign o_CellRdy   = cell_ok_c;
    assign o_MazeMap   = map_q;
    assign o_MazeLevel = mlvl_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Err       = err_q;

endmodule

// File: tb/tb_maze_map_loader.sv
// Bench for maze_map_loader: ROM responder, load/timeout/reset/cell-write
// scenarios, checked against a map model kept as plain arrays.
module tb_maze_map_loader;

    localparam int ROWS    = 30;
    localparam int COLS    = 40;
    localparam int TIMEOUT = 255;
    localparam int MAP_W   = ROWS * COLS;
    localparam int IDX_W   = $clog2(MAP_W);

    logic               i_Clk;
    logic               i_Rst;
    logic               i_Start;
    logic [1:0]         i_Level;
    logic               o_RomReq;
    logic [6:0]         o_RomAddr;
    logic               i_RomAck;
    logic [COLS-1:0]    i_RomData;
    logic               i_FrameDone;
    logic               i_CellWe;
    logic [4:0]         i_CellRow;
    logic [5:0]         i_CellCol;
    logic               i_CellVal;
    logic               o_CellRdy;
    logic [MAP_W-1:0]   o_MazeMap;
    logic [1:0]         o_MazeLevel;
    logic               o_Busy;
    logic               o_Done;
    logic               o_Err;

    maze_map_loader #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Start     (i_Start),
        .i_Level     (i_Level),
        .o_RomReq    (o_RomReq),
        .o_RomAddr   (o_RomAddr),
        .i_RomAck    (i_RomAck),
        .i_RomData   (i_RomData),
        .i_FrameDone (i_FrameDone),
        .i_CellWe    (i_CellWe),
        .i_CellRow   (i_CellRow),
        .i_CellCol   (i_CellCol),
        .i_CellVal   (i_CellVal),
        .o_CellRdy   (o_CellRdy),
        .o_MazeMap   (o_MazeMap),
        .o_MazeLevel (o_MazeLevel),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Err       (o_Err)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ROM contents and responder controls
    logic [COLS-1:0]  rom_mem [0:127];
    logic             stall_en   = 1'b0;
    logic [6:0]       stall_addr = 7'd0;
    logic             noise_en   = 1'b0;
    logic             noise_bit  = 1'b0;
    logic [COLS-1:0]  noise_data = '0;

    // Model of the expected active map/level
    logic [MAP_W-1:0] exp_map;
    logic [1:0]       exp_lvl;

    int unsigned addr_log[$];

    // Zero-wait ROM; stray acks and garbage data appear while no request is up
    always_comb begin
        if (o_RomReq) begin
            i_RomAck  = !(stall_en && (o_RomAddr == stall_addr));
            i_RomData = rom_mem[o_RomAddr];
        end else begin
            i_RomAck  = noise_bit;
            i_RomData = noise_data;
        end
    end

    always @(negedge i_Clk) begin
        noise_bit  <= noise_en && ($urandom_range(1, 0) == 1);
        noise_data <= COLS'({$urandom(), $urandom()});
    end

    // Request trace, plus address-is-zero check whenever no request is up
    always @(negedge i_Clk) begin
        if (i_Rst) begin
            if (o_RomReq) begin
                addr_log.push_back(32'(o_RomAddr));
            end else begin
                n_cmp++;
                assert (o_RomAddr === 7'd0) else begin
                    n_bad++;
                    $error("FAIL addr_idle obs=%0d exp=0", o_RomAddr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_map(input string tag);
        int bad_row;
        bad_row = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (o_MazeMap[IDX_W'(r * COLS) +: COLS] !== exp_map[IDX_W'(r * COLS) +: COLS]) bad_row = r;
        end
        n_cmp++;
        assert (o_MazeMap === exp_map) else begin
            n_bad++;
            $error("FAIL %s row=%0d obs=%0h exp=%0h", tag, bad_row,
                   o_MazeMap[IDX_W'(bad_row * COLS) +: COLS], exp_map[IDX_W'(bad_row * COLS) +: COLS]);
        end
    endtask

    task automatic do_start(input logic [1:0] lvl);
        i_Level = lvl;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
    endtask

    // Full load with zero-wait ROM, stray frame pulses, and a cell write attempt mid-load
    task automatic run_load(input logic [1:0] lvl);
        int eff;
        int base;
        eff  = (lvl == 2'b11) ? 2 : int'(lvl);
        base = eff * ROWS;
        addr_log.delete();
        do_start(lvl);
        chk("start_busy", 64'(o_Busy), 64'd1);
        chk("start_err", 64'(o_Err), 64'd0);
        chk("start_addr", 64'(o_RomAddr), 64'(base));
        for (int k = 1; k <= 2 * ROWS; k++) begin
            if (k == 11 || k == 2 * ROWS) i_FrameDone = 1'b1;
            if (k == 5) begin
                i_CellWe  = 1'b1;
                i_CellRow = 5'd3;
                i_CellCol = 6'd8;
                i_CellVal = ~exp_map[3 * COLS + 8];
                #1;
                chk("cell_rdy_busy", 64'(o_CellRdy), 64'd0);
            end
            tick();
            i_FrameDone = 1'b0;
            i_CellWe    = 1'b0;
            chk("load_busy", 64'(o_Busy), 64'd1);
            chk("load_done", 64'(o_Done), 64'd0);
        end
        chk_map("map_hold_load");
        chk("log_size", 64'(addr_log.size()), 64'(ROWS));
        for (int r = 0; r < ROWS && r < addr_log.size(); r++) begin
            chk("log_addr", 64'(addr_log[r]), 64'(base + r));
        end
        // Pulses before/at entry must not have triggered a swap
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_done", 64'(o_Done), 64'd0);
            chk("wait_busy", 64'(o_Busy), 64'd1);
        end
        chk_map("map_hold_wait");
        i_FrameDone = 1'b1;
        tick();
        i_FrameDone = 1'b0;
        chk("swap_done", 64'(o_Done), 64'd0);
        chk_map("map_hold_swap");
        tick();
        for (int r = 0; r < ROWS; r++) exp_map[IDX_W'(r * COLS) +: COLS] = rom_mem[7'(base + r)];
        exp_lvl = 2'(eff);
        chk_map("map_after_swap");
        chk("level_after_swap", 64'(o_MazeLevel), 64'(exp_lvl));
        chk("done_pulse", 64'(o_Done), 64'd1);
        chk("busy_after_swap", 64'(o_Busy), 64'd0);
        tick();
        chk("done_once", 64'(o_Done), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 64'(o_RomReq), 64'd0);
        chk({tag, "_addr"}, 64'(o_RomAddr), 64'd0);
        chk({tag, "_busy"}, 64'(o_Busy), 64'd0);
        chk({tag, "_done"}, 64'(o_Done), 64'd0);
        chk({tag, "_err"}, 64'(o_Err), 64'd0);
        chk({tag, "_rdy"}, 64'(o_CellRdy), 64'd0);
        chk({tag, "_lvl"}, 64'(o_MazeLevel), 64'd0);
        chk_map({tag, "_map"});
    endtask

    initial begin
        int guard;
        int c5;
        logic [4:0] rr;
        logic [5:0] cc;
        logic       vv;
        logic       exp_rdy;

        i_Rst = 1'b0; i_Start = 1'b0; i_Level = 2'b00; i_FrameDone = 1'b0;
        i_CellWe = 1'b1; i_CellRow = 5'd0; i_CellCol = 6'd0; i_CellVal = 1'b1;
        exp_map = '0;
        exp_lvl = 2'b00;
        for (int a = 0; a < 128; a++) rom_mem[a] = COLS'(a);

        // Reset state, with a cell write held on the inputs
        tick();
        tick();
        chk_all_zero("reset");
        i_CellWe = 1'b0;
        i_Rst = 1'b1;
        tick();

        // Level 01 with data = address
        run_load(2'b01);
        chk("row0_is_30", 64'(o_MazeMap[COLS-1:0]), 64'd30);
        chk("row29_is_59", 64'(o_MazeMap[(ROWS-1)*COLS +: COLS]), 64'd59);

        // Level 11 clamps to 10
        run_load(2'b11);
        chk("row0_is_60", 64'(o_MazeMap[COLS-1:0]), 64'd60);

        // Directed cell writes in IDLE
        i_CellWe = 1'b1; i_CellRow = 5'd3; i_CellCol = 6'd7; i_CellVal = 1'b0;
        #1;
        chk("cell_rdy_3_7a", 64'(o_CellRdy), 64'd1);
        tick();
        exp_map[127] = 1'b0;
        chk_map("cell_3_7_clear");
        i_CellVal = 1'b1;
        #1;
        chk("cell_rdy_3_7b", 64'(o_CellRdy), 64'd1);
        tick();
        exp_map[127] = 1'b1;
        chk_map("cell_3_7_set");
        chk("bit127", 64'(o_MazeMap[127]), 64'd1);
        i_CellRow = 5'd30; i_CellCol = 6'd0;
        #1;
        chk("cell_rdy_row30", 64'(o_CellRdy), 64'd0);
        tick();
        chk_map("cell_row30_drop");

        // Random cell writes, including out-of-range coordinates
        for (int i = 0; i < 24; i++) begin
            rr = 5'($urandom_range(31, 0));
            cc = 6'($urandom_range(63, 0));
            vv = 1'($urandom_range(1, 0));
            exp_rdy = (int'(rr) < ROWS) && (int'(cc) < COLS);
            i_CellRow = rr; i_CellCol = cc; i_CellVal = vv;
            #1;
            chk("cell_rdy_rand", 64'(o_CellRdy), 64'(exp_rdy));
            tick();
            if (exp_rdy) exp_map[IDX_W'(int'(rr) * COLS + int'(cc))] = vv;
            chk_map("cell_rand");
        end
        i_CellWe = 1'b0;

        // Random ROM contents, random levels, stray acks while idle-between-requests
        for (int a = 0; a < 128; a++) rom_mem[a] = COLS'({$urandom(), $urandom()});
        noise_en = 1'b1;
        for (int i = 0; i < 3; i++) run_load(2'($urandom_range(3, 0)));
        noise_en = 1'b0;

        // Timeout at level 0, row 5
        stall_en = 1'b1;
        stall_addr = 7'd5;
        addr_log.delete();
        do_start(2'b00);
        guard = 0;
        while (o_Busy && guard < 600) begin
            tick();
            guard++;
        end
        chk("timeout_exit_busy", 64'(o_Busy), 64'd0);
        chk("timeout_err", 64'(o_Err), 64'd1);
        c5 = 0;
        foreach (addr_log[i]) if (addr_log[i] == 5) c5++;
        chk("timeout_req_cycles", 64'(c5), 64'(TIMEOUT));
        chk("timeout_log_size", 64'(addr_log.size()), 64'(5 + TIMEOUT));
        chk_map("timeout_map_intact");
        chk("timeout_level_intact", 64'(o_MazeLevel), 64'(exp_lvl));
        stall_en = 1'b0;
        tick();
        tick();
        chk("err_sticky", 64'(o_Err), 64'd1);
        run_load(2'b10);

        // Reset in the middle of a load at row 12
        do_start(2'b10);
        guard = 0;
        while (!(o_RomReq && o_RomAddr == 7'd72) && guard < 200) begin
            tick();
            guard++;
        end
        chk("reach_row12", 64'(o_RomAddr), 64'd72);
        #2;
        i_Rst = 1'b0;
        i_CellWe = 1'b1; i_CellRow = 5'd1; i_CellCol = 6'd1;
        #1;
        exp_map = '0;
        exp_lvl = 2'b00;
        chk_all_zero("midreset");
        tick();
        chk_all_zero("midreset_hold");
        i_CellWe = 1'b0;
        i_Rst = 1'b1;
        addr_log.delete();
        for (int k = 0; k < 5; k++) tick();
        chk("post_reset_no_req", 64'(addr_log.size()), 64'd0);
        chk("post_reset_busy", 64'(o_Busy), 64'd0);
        run_load(2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/maze_map_loader.md
MAZE_MAP_LOADER -- requirements
Module: maze_map_loader

Interface
REQ-001 The block SHALL have parameter ROWS, default 30, meaning maze rows loaded per map.
REQ-002 The block SHALL have parameter COLS, default 40, meaning cells per row and the ROM word width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for a ROM acknowledge.
REQ-004 i_Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_Rst  in  1  reset, asynchronous, active-low.
REQ-006 i_Start  in  1  one-cycle pulse requesting a map load.
REQ-007 i_Level  in  2  requested level; 00 Easy, 01 Normal, 10 Hard; 11 is treated as 10.
REQ-008 o_RomReq  out  1  ROM row-read request.
REQ-009 o_RomAddr  out  7  ROM row address, level*ROWS + row.
REQ-010 i_RomAck  in  1  ROM acknowledge; i_RomData is valid in the same cycle.
REQ-011 i_RomData  in  COLS  row bitmap; bit c is column c, 1 = wall.
REQ-012 i_FrameDone  in  1  end-of-frame pulse from the draw path.
REQ-013 i_CellWe, i_CellRow[4:0], i_CellCol[5:0], i_CellVal  in  cell write request to the active map.
REQ-014 o_CellRdy  out  1  cell write accepted this cycle.
REQ-015 o_MazeMap  out  ROWS*COLS  active map; row r occupies bits [COLS*r +: COLS].
REQ-016 o_MazeLevel  out  2  level of the active map.
REQ-017 o_Busy, o_Done, o_Err  out  1 each  loading; one-cycle completion pulse; sticky load error.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, NEXT, WAIT_FRAME and SWAP.
REQ-019 IDLE: on i_Start, latch the clamped level, clear row and timeout counters, clear o_Err, go to REQ.
REQ-020 IDLE: an i_Start arriving in any other state SHALL be ignored.
REQ-021 REQ: o_RomReq=1 and o_RomAddr=level*ROWS+row held stable until acknowledged.
REQ-022 REQ: on i_RomAck, write i_RomData into shadow row "row" at that edge and go to NEXT.
REQ-023 REQ: the timeout counter SHALL increment each cycle without acknowledge.
REQ-024 REQ: if the timeout counter reaches TIMEOUT, set o_Err, discard the shadow map, leave the active map unchanged, and go to IDLE.
REQ-025 NEXT: o_RomReq=0 for exactly one cycle, giving one idle cycle between requests.
REQ-026 NEXT: if row==ROWS-1, go to WAIT_FRAME; otherwise increment row, clear the timeout counter and go to REQ.
REQ-027 i_RomAck outside REQ SHALL be ignored.
REQ-028 WAIT_FRAME: go to SWAP only on i_FrameDone sampled while in this state; earlier pulses do not count.
REQ-029 SWAP: copy the whole shadow map to o_MazeMap, copy the latched level to o_MazeLevel, pulse o_Done for one cycle, and go to IDLE.
REQ-030 The active map SHALL change only in SWAP or through an accepted cell write, so a frame never shows a partial map.
REQ-031 o_Busy SHALL be 1 in REQ, NEXT, WAIT_FRAME and SWAP, and 0 in IDLE.
REQ-032 o_CellRdy SHALL equal i_CellWe and (state==IDLE), with i_CellRow<ROWS and i_CellCol<COLS.
REQ-033 An accepted write SHALL set o_MazeMap bit COLS*row+col to i_CellVal at that edge; writes that are not accepted are dropped, not queued.
REQ-034 Minimum load latency SHALL be 2*ROWS+1 cycles from i_Start to entering WAIT_FRAME with zero-wait acknowledges.
REQ-035 o_RomAddr arithmetic SHALL be unsigned with a 7-bit result; the maximum value is 89.
REQ-036 o_RomAddr SHALL be 0 when o_RomReq=0.

Reset
REQ-037 Asserting i_Rst low SHALL immediately force IDLE, counters 0, shadow map 0, o_MazeMap 0, o_MazeLevel 00, and o_RomReq, o_Busy, o_Done, o_Err and o_CellRdy to 0.
REQ-038 Reset during a load SHALL abandon the load with no ROM request after release until the next i_Start.

Verification
REQ-039 Start with i_Level=01 and an always-acknowledging ROM returning data=address -> o_RomAddr runs 30..59, each for one cycle with a one-cycle gap; the map is unchanged until i_FrameDone; one cycle after that, o_MazeMap row r=30+r, o_MazeLevel=01, o_Done pulses once.
REQ-040 Start with i_Level=11 -> o_RomAddr starts at 60 and o_MazeLevel=10 after the swap.
REQ-041 ROM never acknowledges at row 5 -> o_RomReq is high for 255 cycles at address 5, then o_Err=1, o_Busy=0, the prior map is intact, and a later i_Start clears o_Err.
REQ-042 i_FrameDone pulses during REQ and again in the same cycle the FSM enters WAIT_FRAME -> no swap; the swap occurs on the first pulse sampled inside WAIT_FRAME.
REQ-043 Cell writes (row 3, col 7, val 1) in IDLE, (row 30, col 0) in IDLE, and (row 3, col 8) during REQ -> only bit 127 is set, and o_CellRdy is 1 only for the first.
REQ-044 Reset asserted at row 12, then released and i_Start issued -> all outputs are zero during reset and the load restarts at the level base address with row 0.
